// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch elapsed-time core.
// Digit chain is SS.cc: hundredths, tenths, seconds, tens of seconds.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam int DIGIT_W  = 4;
  localparam int NUM_W    = 16;
  localparam int MOD_HUN  = 10;
  localparam int MOD_TEN  = 10;
  localparam int MOD_SEC  = 10;
  localparam int MOD_TSEC = 6;

endpackage

// File: rtl/stopwatch_bcd_timer_bcd_digit_counter.sv
// One BCD digit of the elapsed-time chain.
// carry is combinational so a whole chain rolls in a single edge.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(MODULUS - 1);

  assign carry = inc && (digit == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= (digit == MAX) ? '0 : digit + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_timer.sv
// Stopwatch core: FSM, 1/100 s prescaler, BCD chain, wrap and lap hold.
// Lap hold is built only when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_bcd_timer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int DIV_W    = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             lap,
  output logic [NUM_W-1:0] number,
  output logic             running,
  output logic             wrap,
  output logic             lap_held
);

  localparam logic [DIV_W-1:0] PRE_MAX = DIV_W'(TICK_DIV - 1);

  sw_state_t state_q, state_d;
  logic [DIV_W-1:0] presc_q;
  logic run_on, tick, to_idle, start_idle;
  logic [DIGIT_W-1:0] d0, d1, d2, d3;
  logic c0, c1, c2, c3;
  logic [NUM_W-1:0] live;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_stop) state_d = RUN;
      RUN:   if (start_stop) state_d = PAUSE;
      PAUSE: begin
        if (clear) state_d = IDLE;
        else if (start_stop) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Stopping wins over a coincident tick: the prescaler only advances
  // on edges that stay in RUN, so a resume picks up the exact phase.
  assign run_on     = (state_q == RUN) && !start_stop;
  assign tick       = run_on && (presc_q == PRE_MAX);
  assign to_idle    = (state_q == PAUSE) && clear;
  assign start_idle = (state_q == IDLE) && start_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (to_idle || start_idle) begin
      presc_q <= '0;
    end else if (run_on) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  bcd_digit_counter #(.MODULUS(MOD_HUN)) u_hun (
    .clk(clk), .rst_n(rst_n), .clr(to_idle),
    .inc(tick), .digit(d0), .carry(c0)
  );

  bcd_digit_counter #(.MODULUS(MOD_TEN)) u_ten (
    .clk(clk), .rst_n(rst_n), .clr(to_idle),
    .inc(c0), .digit(d1), .carry(c1)
  );

  bcd_digit_counter #(.MODULUS(MOD_SEC)) u_sec (
    .clk(clk), .rst_n(rst_n), .clr(to_idle),
    .inc(c1), .digit(d2), .carry(c2)
  );

  bcd_digit_counter #(.MODULUS(MOD_TSEC)) u_tsec (
    .clk(clk), .rst_n(rst_n), .clr(to_idle),
    .inc(c2), .digit(d3), .carry(c3)
  );

  assign live = {d3, d2, d1, d0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap <= 1'b0;
    else        wrap <= c3;
  end

  assign running = (state_q == RUN);

`ifdef STOPWATCH_LAP_HOLD_EN
  logic [NUM_W-1:0] snap_q;
  logic             held_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
      held_q <= 1'b0;
    end else if (to_idle) begin
      held_q <= 1'b0;
    end else if (lap && (state_q != IDLE)) begin
      if (!held_q) begin
        snap_q <= live;
        held_q <= 1'b1;
      end else begin
        held_q <= 1'b0;
      end
    end
  end

  assign lap_held = held_q;
  assign number   = held_q ? snap_q : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_held   = 1'b0;
  assign number     = live;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_timer.sv
// Randomised and directed bench for stopwatch_bcd_timer (TICK_DIV=4).
// Reference: elapsed time = floor(counted run cycles / 4) mod 6000.
module tb_stopwatch_bcd_timer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic [15:0] number;
  logic        running;
  logic        wrap;
  logic        lap_held;

  int tests = 0;
  int fails = 0;

  // model: 0 idle, 1 run, 2 pause
  int          m_st = 0;
  int          m_edges = 0;
  bit          m_wrap = 0;
  bit          m_held = 0;
  logic [15:0] m_snap = '0;

  stopwatch_bcd_timer #(.TICK_DIV(TD), .DIV_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop),
    .clear(clear), .lap(lap), .number(number),
    .running(running), .wrap(wrap), .lap_held(lap_held)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd(input int c);
    int s, h;
    s = c / 100;
    h = c % 100;
    return {4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  function automatic logic [15:0] m_live();
    return bcd((m_edges / TD) % 6000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("number", {16'h0, number}, {16'h0, m_held ? m_snap : m_live()});
    chk("running", {31'h0, running}, {31'h0, m_st == 1});
    chk("wrap", {31'h0, wrap}, {31'h0, m_wrap});
    chk("lap_held", {31'h0, lap_held}, {31'h0, m_held});
  endtask

  task automatic step(input bit ss, input bit cl, input bit lp);
    logic [15:0] live_pre;
    bit          lap_ok;
    start_stop = ss;
    clear = cl;
    lap = lp;
    @(posedge clk);
    live_pre = m_live();
    lap_ok = (m_st != 0) && !(m_st == 2 && cl);
    m_wrap = 0;
    case (m_st)
      0: if (ss) m_st = 1;
      1: begin
        if (ss) m_st = 2;
        else begin
          m_edges++;
          if (m_edges % TD == 0 && (m_edges / TD) % 6000 == 0)
            m_wrap = 1;
        end
      end
      default: begin
        if (cl) begin
          m_st = 0;
          m_edges = 0;
          m_held = 0;
        end else if (ss) m_st = 1;
      end
    endcase
`ifdef STOPWATCH_LAP_HOLD_EN
    if (lp && lap_ok) begin
      if (!m_held) begin
        m_snap = live_pre;
        m_held = 1;
      end else m_held = 0;
    end
`else
    if (lp && lap_ok) m_held = 0;
`endif
    #1;
    start_stop = 1'b0;
    clear = 1'b0;
    lap = 1'b0;
    chk_all();
  endtask

  task automatic go_idle();
    if (m_st == 1) step(1, 0, 0);
    if (m_st == 2) step(0, 1, 0);
  endtask

  initial begin
    int wraps;
    #3;
    chk("rst_number", {16'h0, number}, 32'h0);
    chk("rst_running", {31'h0, running}, 32'h0);
    #9 rst_n = 1'b1;
    repeat (3) step(0, 0, 0);

    // start and count
    step(1, 0, 0);
    chk("start_running", {31'h0, running}, 32'h1);
    repeat (TD) step(0, 0, 0);
    chk("first_inc", {16'h0, number}, 32'h0001);
    repeat (40 - TD) step(0, 0, 0);
    chk("ten_ticks", {16'h0, number}, 32'h0010);

    // pause mid-count, hold, clear ignored in run, resume
    repeat (2) step(0, 0, 0);
    step(1, 0, 0);
    repeat (50) step(0, 0, 0);
    chk("paused_frozen", {16'h0, number}, 32'h0010);
    step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    step(0, 1, 0);
    chk("run_clear_ign", {31'h0, running}, 32'h1);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("pause_clear", {16'h0, number}, 32'h0);

    // start_stop coinciding with a tick: no increment
    step(1, 0, 0);
    repeat (TD - 1) step(0, 0, 0);
    step(1, 0, 0);
    chk("ss_on_tick", {16'h0, number}, 32'h0000);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("resume_tick", {16'h0, number}, 32'h0001);

    // simultaneous inputs
    repeat (9) step(0, 0, 0);
    step(1, 1, 0);
    chk("run_ss_clr", {31'h0, running}, 32'h0);
    step(1, 1, 0);
    chk("pause_ss_clr", {16'h0, number}, 32'h0);

    // lap hold
    step(1, 0, 0);
    repeat (25 * TD) step(0, 0, 0);
    step(0, 0, 1);
    repeat (60 * TD - 25 * TD - 1) step(0, 0, 0);
`ifdef STOPWATCH_LAP_HOLD_EN
    chk("lap_hold", {16'h0, number}, 32'h0025);
`else
    chk("lap_ignored", {16'h0, number}, 32'h0060);
`endif
    go_idle();
    step(1, 0, 0);
    repeat (25 * TD) step(0, 0, 0);
    step(0, 0, 1);
    repeat (40 * TD - 25 * TD - 1) step(0, 0, 0);
    step(0, 0, 1);
    chk("lap_release", {16'h0, number}, 32'h0040);
    chk("lap_rel_flag", {31'h0, lap_held}, 32'h0);

    // async reset mid-run
    repeat (7) step(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_number", {16'h0, number}, 32'h0);
    chk("async_running", {31'h0, running}, 32'h0);
    chk("async_lap", {31'h0, lap_held}, 32'h0);
    @(posedge clk);
    #1 chk("rst_hold", {16'h0, number}, 32'h0);
    #3 rst_n = 1'b1;
    m_st = 0;
    m_edges = 0;
    m_held = 0;
    m_wrap = 0;
    repeat (20) step(0, 0, 0);

    // full wrap
    step(1, 0, 0);
    wraps = 0;
    repeat (6000 * TD) begin
      step(0, 0, 0);
      if (wrap) wraps++;
    end
    chk("wrap_count", wraps, 1);
    chk("wrap_number", {16'h0, number}, 32'h0);
    chk("wrap_running", {31'h0, running}, 32'h1);

    // random pulses
    repeat (3000) begin
      step($urandom_range(15) == 0, $urandom_range(7) == 0,
           $urandom_range(7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
